reg_dump_reader: RTL and testbench
==================================

# reg_dump_reader

Sequential read-side client for the 16×16 processor register file: on a start pulse it walks register indices 0..REG_COUNT-1 through one register-file read port, captures each value and streams it out over a valid/ready handshake. It sits beside the core as a debug/scan-out engine: test benches, a debug UART or a trace buffer pull architectural state through it without touching the datapath write port.

## Interface
- REG_COUNT, 16: number of registers dumped, indices 0..REG_COUNT-1; legal range 1..16.
- DATA_WIDTH, 16: register width.
- clk  input  1  single clock; all state updates on rising edge.
- rst  input  1  asynchronous, active-high reset.
- start  input  1  one-cycle request to begin a dump; honoured only in IDLE.
- abort  input  1  synchronous cancel; honoured in READ and SEND.
- busy  output  1  high in READ and SEND.
- done  output  1  one-cycle pulse after the last word is accepted.
- rf_src_reg  output  4  register-file read address (to src_reg of one read port).
- rf_src_data  input  DATA_WIDTH  register-file read data (combinational, includes write bypass).
- out_valid  output  1  out_data/out_idx/out_last valid.
- out_ready  input  1  consumer accepts the current word.
- out_data  output  DATA_WIDTH  captured register value.
- out_idx  output  4  index of out_data.
- out_last  output  1  marks index REG_COUNT-1.

## Operation
- States: IDLE, READ, SEND, DONE.
- IDLE: busy=0, out_valid=0. start=1 -> idx<=0, go READ. abort ignored.
- READ: rf_src_reg=idx; at edge capture out_data<=rf_src_data, out_idx<=idx, out_last<=(idx==REG_COUNT-1); go SEND. abort=1 -> IDLE, nothing captured.
- SEND: out_valid=1; out_data/out_idx/out_last held stable until handshake (out_valid & out_ready at edge). Handshake with out_last=0 -> idx<=idx+1, go READ. Handshake with out_last=1 -> go DONE.
- abort in SEND: -> IDLE; the pending word is dropped even if out_ready=1 in the same cycle (abort wins); done not asserted.
- DONE: done=1 for exactly one cycle, -> IDLE unconditionally. start during DONE ignored.
- start while busy or in DONE: ignored, no queuing.
- rf_src_reg is the idx register, driven in every state; idx holds its value outside READ/SEND except on restart.
- Dump is not an atomic snapshot: a register written before its READ cycle returns the new value; a write in the same cycle as READ to the same index returns dst_data via the register file's bypass.
- idx is 4 bits; REG_COUNT=16 terminates on out_last, never wraps to 0.

## Timing
- Reset values: state=IDLE, idx=0, busy=0, done=0, rf_src_reg=0, out_valid=0, out_data=0, out_idx=0, out_last=0.
- rst asserted mid-dump: all outputs return to reset values immediately (asynchronous), no done.
- Per word: 1 READ cycle + ≥1 SEND cycle; with out_ready tied high, full dump = 2*REG_COUNT cycles from start edge to last handshake, done in the following cycle (2*REG_COUNT+1 total).
- First out_valid: 2 cycles after the edge sampling start.
- out_valid never drops without a handshake, abort or reset.
- All outputs registered except none; no combinational path from out_ready to any output.

## Structure
- Shared package: state enum (IDLE, READ, SEND, DONE), REG_IDX_W=4 constant, default DATA_WIDTH.
- Single module; no sub-module needed. Optionally instantiate the team register file in the bench only.

## Test plan
- Registers preloaded r[i]=16'h1000+i, out_ready=1, start pulse -> 16 words 16'h1000..16'h100F, idx 0..15, out_last only on idx 15, done 33 cycles after start.
- out_ready low 3 cycles at idx 5 -> out_valid held, out_data=16'h1005 stable all 3 cycles, no skipped or duplicated index.
- start re-pulsed at idx 7 -> ignored, sequence continues to 15, single done.
- abort in SEND at idx 4 with out_ready=1 -> word 4 not accepted, IDLE next cycle, no done; new start dumps from idx 0.
- rst asserted during READ of idx 9 -> outputs zero immediately; after release, start dumps 0..15 correctly.
- Write r3<=16'hBEEF in same cycle as READ of idx 3 -> out_data=16'hBEEF (bypass); write to r2 after its capture -> dump shows old r2.

Source files
------------

// File: rtl/reg_dump_reader_pkg.sv
// Shared types and constants for the register-dump reader.
// State encoding, register-index width and the default data width.
// Imported by the reader top and by anything that decodes its state.
package reg_dump_reader_pkg;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_READ = 2'd1,
    S_SEND = 2'd2,
    S_DONE = 2'd3
  } state_t;

  localparam int REG_IDX_W          = 4;
  localparam int DEFAULT_DATA_WIDTH = 16;

endpackage

// File: rtl/reg_dump_reader.sv
// Walks register indices 0..REG_COUNT-1 through one register-file read port and streams the values out.
// Latency: one READ cycle per word, then out_valid the next cycle; done pulses one cycle after the last accept.
// Backpressure: each word is held stable on out_* until out_valid & out_ready; abort drops the pending word.
module reg_dump_reader
  import reg_dump_reader_pkg::*;
#(
  parameter int REG_COUNT  = 16,
  parameter int DATA_WIDTH = DEFAULT_DATA_WIDTH
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  start,
  input  logic                  abort,
  output logic                  busy,
  output logic                  done,
  output logic [REG_IDX_W-1:0]  rf_src_reg,
  input  logic [DATA_WIDTH-1:0] rf_src_data,
  output logic                  out_valid,
  input  logic                  out_ready,
  output logic [DATA_WIDTH-1:0] out_data,
  output logic [REG_IDX_W-1:0]  out_idx,
  output logic                  out_last
);

  localparam logic [REG_IDX_W-1:0] LAST_IDX = REG_IDX_W'(REG_COUNT - 1);

  state_t               state;
  state_t               state_nxt;
  logic [REG_IDX_W-1:0] idx;
  logic [REG_IDX_W-1:0] idx_nxt;
  logic                 capture;

  // The read address is the index register itself, so it is registered and
  // keeps its last value while idle.
  assign rf_src_reg = idx;

  // Next-state and index update; abort takes priority over a same-cycle handshake.
  always_comb begin
    state_nxt = state;
    idx_nxt   = idx;
    capture   = 1'b0;
    case (state)
      S_IDLE: begin
        if (start) begin
          idx_nxt   = '0;
          state_nxt = S_READ;
        end
      end
      S_READ: begin
        if (abort) begin
          state_nxt = S_IDLE;
        end else begin
          capture   = 1'b1;
          state_nxt = S_SEND;
        end
      end
      S_SEND: begin
        if (abort) begin
          state_nxt = S_IDLE;
        end else if (out_valid && out_ready) begin
          if (out_last) begin
            state_nxt = S_DONE;
          end else begin
            idx_nxt   = idx + 1'b1;
            state_nxt = S_READ;
          end
        end
      end
      S_DONE: begin
        state_nxt = S_IDLE;
      end
      default: begin
        state_nxt = S_IDLE;
      end
    endcase
  end

  // State and index registers.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state <= S_IDLE;
      idx   <= '0;
    end else begin
      state <= state_nxt;
      idx   <= idx_nxt;
    end
  end

  // Status flags are decoded from the next state so they come straight off flops.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      busy      <= 1'b0;
      done      <= 1'b0;
      out_valid <= 1'b0;
    end else begin
      busy      <= (state_nxt == S_READ) || (state_nxt == S_SEND);
      done      <= (state_nxt == S_DONE);
      out_valid <= (state_nxt == S_SEND);
    end
  end

  // Word capture at the end of the READ cycle; held until the next capture.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      out_data <= '0;
      out_idx  <= '0;
      out_last <= 1'b0;
    end else if (capture) begin
      out_data <= rf_src_data;
      out_idx  <= idx;
      out_last <= (idx == LAST_IDX);
    end
  end

endmodule

// File: tb/tb_reg_dump_reader.sv
// Self-checking bench for reg_dump_reader with a behavioural register file.
// Expected words are queued by the stimulus; a negedge monitor pops and compares on each accept.
// Also checks hold-stability under backpressure, done timing, abort and asynchronous reset.
module tb_reg_dump_reader;

  localparam int NREG = 16;

  typedef struct packed {
    logic [15:0] data;
    logic [3:0]  idx;
    logic        last;
  } word_t;

  logic        clk = 1'b0;
  logic        rst;
  logic        start;
  logic        abort;
  logic        busy;
  logic        done;
  logic [3:0]  rf_src_reg;
  logic [15:0] rf_src_data;
  logic        out_valid;
  logic        out_ready;
  logic [15:0] out_data;
  logic [3:0]  out_idx;
  logic        out_last;

  // Register file environment: combinational read with write bypass.
  logic [15:0] rf [NREG];
  logic [15:0] init_val [NREG];
  logic        load;
  logic        we;
  logic [3:0]  wa;
  logic [15:0] wd;

  word_t exp_q[$];
  int    n_tests = 0;
  int    n_fail  = 0;
  int    done_seen = 0;
  int    done_exp  = 0;

  always #5 clk = ~clk;

  reg_dump_reader #(.REG_COUNT(NREG), .DATA_WIDTH(16)) dut (
    .clk        (clk),
    .rst        (rst),
    .start      (start),
    .abort      (abort),
    .busy       (busy),
    .done       (done),
    .rf_src_reg (rf_src_reg),
    .rf_src_data(rf_src_data),
    .out_valid  (out_valid),
    .out_ready  (out_ready),
    .out_data   (out_data),
    .out_idx    (out_idx),
    .out_last   (out_last)
  );

  always @(posedge clk) begin
    if (load) begin
      for (int i = 0; i < NREG; i++) rf[i] <= init_val[i];
    end else if (we) begin
      rf[wa] <= wd;
    end
  end

  assign rf_src_data = (we && (wa == rf_src_reg)) ? wd : rf[rf_src_reg];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic pulse_start();
    start = 1'b1;
    step();
    start = 1'b0;
  endtask

  // Reference: word i of a dump is register i as seen when it is read.
  task automatic push_words(input int n);
    word_t w;
    for (int i = 0; i < n; i++) begin
      w.data = rf[i];
      w.idx  = 4'(i);
      w.last = (i == NREG - 1);
      exp_q.push_back(w);
    end
  endtask

  task automatic preload(input logic [15:0] base, input bit rnd);
    for (int i = 0; i < NREG; i++)
      init_val[i] = rnd ? 16'($urandom) : base + 16'(i);
    load = 1'b1;
    step();
    load = 1'b0;
  endtask

  // Drives out_ready randomly at pct% until done appears; returns cycles used.
  task automatic wait_done(input int pct, output int cycles);
    cycles = 0;
    while (1) begin
      out_ready = ($urandom_range(99) < pct);
      step();
      cycles++;
      if (done) break;
      if (cycles > 400) begin
        chk("done_timeout", 32'(cycles), 32'(0));
        break;
      end
    end
    out_ready = 1'b1;
  endtask

  // Monitor: compares each accepted word and checks hold stability under backpressure.
  word_t h_word;
  bit    hold_chk = 1'b0;
  always @(negedge clk) begin
    word_t e;
    word_t a;
    if (rst) begin
      hold_chk = 1'b0;
    end else begin
      a = '{data: out_data, idx: out_idx, last: out_last};
      if (done) done_seen++;
      if (hold_chk) begin
        chk("hold_valid", 32'(out_valid), 32'(1));
        chk("hold_word", 32'(a), 32'(h_word));
      end
      hold_chk = 1'b0;
      if (out_valid && !abort) begin
        if (out_ready) begin
          if (exp_q.size() == 0) begin
            chk("unexpected_word", 32'(a), 32'hFFFF_FFFF);
          end else begin
            e = exp_q.pop_front();
            chk("word", 32'(a), 32'(e));
          end
        end else begin
          hold_chk = 1'b1;
          h_word   = a;
        end
      end
    end
  end

  initial begin
    int cyc;
    rst = 1'b1; start = 1'b0; abort = 1'b0; out_ready = 1'b1;
    load = 1'b0; we = 1'b0; wa = '0; wd = '0;
    for (int i = 0; i < NREG; i++) init_val[i] = '0;
    step();
    step();
    chk("rst_busy", 32'(busy), 0);
    chk("rst_done", 32'(done), 0);
    chk("rst_valid", 32'(out_valid), 0);
    chk("rst_src_reg", 32'(rf_src_reg), 0);
    chk("rst_data", 32'(out_data), 0);
    chk("rst_idx", 32'(out_idx), 0);
    chk("rst_last", 32'(out_last), 0);
    rst = 1'b0;
    step();

    // Full dump with out_ready high: 16 words, done 2*16 edges after the start edge.
    preload(16'h1000, 1'b0);
    push_words(NREG);
    pulse_start();
    chk("busy_after_start", 32'(busy), 1);
    wait_done(100, cyc);
    done_exp++;
    chk("done_latency", 32'(cyc), 32'(2 * NREG));
    start = 1'b1;
    step();
    start = 1'b0;
    chk("done_one_cycle", 32'(done), 0);
    chk("start_in_done_ignored", 32'(busy), 0);
    step();

    // Backpressure: out_ready low for 3 cycles while word 5 is presented.
    push_words(NREG);
    pulse_start();
    repeat (11) step();
    out_ready = 1'b0;
    for (int k = 0; k < 3; k++) begin
      chk("bp_valid", 32'(out_valid), 1);
      chk("bp_data", 32'(out_data), 32'h1005);
      chk("bp_idx", 32'(out_idx), 5);
      step();
    end
    out_ready = 1'b1;
    wait_done(100, cyc);
    done_exp++;
    step();

    // start re-pulsed mid-dump at index 7: ignored.
    push_words(NREG);
    pulse_start();
    repeat (14) step();
    chk("restart_busy", 32'(busy), 1);
    pulse_start();
    wait_done(100, cyc);
    done_exp++;
    chk("restart_latency", 32'(cyc), 32'(2 * NREG - 15));
    step();

    // abort while word 4 is presented with out_ready high: word dropped, no done.
    push_words(4);
    pulse_start();
    repeat (9) step();
    chk("abort_at_idx", 32'(out_idx), 4);
    abort = 1'b1;
    step();
    abort = 1'b0;
    chk("abort_busy", 32'(busy), 0);
    chk("abort_valid", 32'(out_valid), 0);
    repeat (3) step();
    chk("abort_no_done", 32'(done_seen), 32'(done_exp));
    push_words(NREG);
    pulse_start();
    wait_done(100, cyc);
    done_exp++;
    step();

    // Asynchronous reset during the READ of index 9.
    push_words(9);
    pulse_start();
    repeat (18) step();
    chk("pre_rst_src_reg", 32'(rf_src_reg), 9);
    rst = 1'b1;
    #1;
    chk("arst_busy", 32'(busy), 0);
    chk("arst_valid", 32'(out_valid), 0);
    chk("arst_data", 32'(out_data), 0);
    chk("arst_idx", 32'(out_idx), 0);
    chk("arst_src_reg", 32'(rf_src_reg), 0);
    step();
    rst = 1'b0;
    step();
    push_words(NREG);
    pulse_start();
    wait_done(100, cyc);
    done_exp++;
    step();

    // Write to r3 during its READ cycle (bypass) and to r2 after it was captured.
    push_words(NREG);
    exp_q[3].data = 16'hBEEF;
    pulse_start();
    repeat (6) step();
    we = 1'b1; wa = 4'd3; wd = 16'hBEEF;
    step();
    wa = 4'd2; wd = 16'hDEAD;
    step();
    we = 1'b0;
    wait_done(100, cyc);
    done_exp++;
    chk("r2_written", 32'(rf[2]), 32'hDEAD);
    step();

    // Randomised contents and random backpressure.
    for (int d = 0; d < 6; d++) begin
      preload(16'h0, 1'b1);
      push_words(NREG);
      pulse_start();
      wait_done(55, cyc);
      done_exp++;
      step();
    end

    repeat (2) step();
    chk("done_count", 32'(done_seen), 32'(done_exp));
    chk("queue_drained", 32'(exp_q.size()), 0);
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
